// File: rtl/router_pkg.sv
// Shared defaults and packet-tracking state encoding for the router output-port FIFO.
package router_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int LEN_LSB_DEF = 2;
    localparam int LEN_MSB_DEF = 7;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
module router_fifo_mem #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware per-output-port FIFO: stores header-tagged bytes, tracks packet
// boundaries from the header length field and flags framing errors on the read side.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = LEN_LSB_DEF,
    parameter int LEN_MSB  = LEN_MSB_DEF,
    parameter int AF_LEVEL = 14
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   soft_reset,
    input  logic                   write_enb,
    input  logic                   read_enb,
    input  logic                   lfd_state,
    input  logic [DATA_W-1:0]      datain,
    output logic                   full,
    output logic                   almost_full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [DATA_W-1:0]      dataout,
    output logic                   dout_valid,
    output logic                   sop_out,
    output logic                   eop_out,
    output logic                   pkt_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = AW + 1;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;
    localparam int RW    = LEN_W + 1;

    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     level_q;
    logic              tag_q;
    pkt_state_e        state_q, state_d;
    logic [RW-1:0]     remain_q, remain_d;
    logic [DATA_W-1:0] dataout_q;
    logic              dout_valid_q;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;
    logic              err_q, err_d;

    logic              wr_ok, rd_ok;
    logic [DATA_W:0]   rd_entry;
    logic              rd_hdr;
    logic [RW-1:0]     hdr_remain;

    router_fifo_mem #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i ({tag_q, datain}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    assign full        = (level_q == LW'(DEPTH));
    assign empty       = (level_q == '0);
    assign almost_full = (level_q >= LW'(AF_LEVEL));
    assign level       = level_q;

    assign wr_ok = write_enb & ~full;
    assign rd_ok = read_enb & ~empty;

    assign rd_hdr     = rd_entry[DATA_W];
    // Payload plus the trailing parity byte.
    assign hdr_remain = {1'b0, rd_entry[LEN_MSB:LEN_LSB]} + RW'(1);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        err_d    = 1'b0;
        if (rd_ok) begin
            case (state_q)
                IDLE: begin
                    if (rd_hdr) begin
                        remain_d = hdr_remain;
                        sop_d    = 1'b1;
                        state_d  = IN_PKT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (rd_hdr) begin
                        err_d    = 1'b1;
                        sop_d    = 1'b1;
                        remain_d = hdr_remain;
                    end else begin
                        remain_d = remain_q - RW'(1);
                        if (remain_q == RW'(1)) begin
                            eop_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            tag_q        <= 1'b0;
            state_q      <= IDLE;
            remain_q     <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            tag_q        <= 1'b0;
            state_q      <= IDLE;
            remain_q     <= '0;
            dataout_q    <= '0;
            dout_valid_q <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            tag_q        <= lfd_state;
            state_q      <= state_d;
            remain_q     <= remain_d;
            dout_valid_q <= rd_ok;
            sop_q        <= sop_d;
            eop_q        <= eop_d;
            err_q        <= err_d;
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                dataout_q <= rd_entry[DATA_W-1:0];
            end
            case ({wr_ok, rd_ok})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign dataout    = dataout_q;
    assign dout_valid = dout_valid_q;
    assign sop_out    = sop_q;
    assign eop_out    = eop_q;
    assign pkt_err    = err_q;

endmodule
